gray_stream_decoder: RTL

Streaming Gray-to-binary decoder with valid/ready handshake on both sides. Accepts WIDTH-bit Gray-coded samples (the encoding produced by the team's binary-to-Gray converter, e.g. from a Gray counter crossing a clock boundary) and returns registered binary values one cycle later. An optional step checker flags any accepted sample whose Hamming distance from the previous accepted sample is not exactly 1, and counts such faults. Sits on the receive side of Gray-coded pointer and position paths.

---
 rtl/gray_stream_decoder.sv | 104 ++++++++++
 1 files changed

// File: rtl/gray_stream_decoder.sv
// Streaming Gray-to-binary decoder with valid/ready handshake and a registered result.
// Define GRAY_STEP_CHECK_EN to build the step-distance checker and the error counter.
module gray_stream_decoder #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_gray,
   input  logic             resync,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_bin,
   output logic             out_step_err,
   output logic [7:0]       err_count
);

   logic             accept;
   logic [WIDTH-1:0] decoded;
   logic             out_valid_reg;
   logic [WIDTH-1:0] out_bin_reg;

   assign in_ready  = !out_valid_reg || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_reg;
   assign out_bin   = out_bin_reg;

   // Each binary bit is the parity of all Gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_decode
         assign decoded[gi] = ^in_gray[WIDTH-1:gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_bin_reg   <= '0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_bin_reg   <= decoded;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

`ifdef GRAY_STEP_CHECK_EN
   typedef enum logic {NOREF, TRACK} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] ref_reg;
   logic             step_err;
   logic             out_step_err_reg;
   logic [7:0]       err_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= NOREF;
      end else begin
         state_reg <= state_next;
      end
   end

   // A resync coinciding with an accept makes that sample the fresh reference.
   always_comb begin
      state_next = state_reg;
      step_err   = 1'b0;
      if (accept) begin
         state_next = TRACK;
         if (state_reg == TRACK && !resync) begin
            step_err = ($countones(in_gray ^ ref_reg) != 1);
         end
      end else if (resync) begin
         state_next = NOREF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_reg          <= '0;
         out_step_err_reg <= 1'b0;
         err_count_reg    <= 8'd0;
      end else if (accept) begin
         ref_reg          <= in_gray;
         out_step_err_reg <= step_err;
         if (step_err && err_count_reg != 8'hFF) begin
            err_count_reg <= err_count_reg + 8'd1;
         end
      end
   end

   assign out_step_err = out_step_err_reg;
   assign err_count    = err_count_reg;
`else
   logic unused_resync;

   assign unused_resync = resync;
   assign out_step_err  = 1'b0;
   assign err_count     = 8'd0;
`endif

endmodule
